sobel_gradient: RTL and testbench



---
 rtl/sobel_gradient_if.sv | 20 ++
 rtl/sobel_gradient.sv | 126 ++++++++++++
 tb/tb_sobel_gradient.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sobel_gradient_if.sv
// Pixel-in / gradient-out stream bundle for the Sobel stage.
// The master drives pixels and receives gradients. The slave is the Sobel core.
interface sobel_gradient_if #(
  parameter int COLOR_CHANNEL = 8
);
  logic                                 i_data_ready;
  logic [2:0][COLOR_CHANNEL-1:0]        i_pixel;
  logic                                 o_data_ready;
  logic [1:0][2:0][COLOR_CHANNEL-1:0]   o_convolution_value;

  modport master (
    output i_data_ready, i_pixel,
    input  o_data_ready, o_convolution_value
  );

  modport slave (
    input  i_data_ready, i_pixel,
    output o_data_ready, o_convolution_value
  );
endinterface

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel stage. It uses two line buffers and a 3x3 window per channel, followed by a
// 3-stage pipeline. The outputs are |Gx|>>2 and |Gy|>>2 for each RGB channel, for interior pixels only.
module sobel_gradient #(
  parameter int COLOR_CHANNEL = 8,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480
) (
  input  logic             i_clk,
  input  logic             i_reset,
  sobel_gradient_if.slave  stream
);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int PW = COLOR_CHANNEL + 2;
  localparam int DW = COLOR_CHANNEL + 3;

  typedef logic [COLOR_CHANNEL-1:0] pix_t;

  logic          accept;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          valid_s1, valid_s2;
  pix_t          gx_mag [3];
  pix_t          gy_mag [3];

  assign accept = stream.i_data_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(IMAGE_WIDTH - 1)) begin
        col <= '0;
        row <= (row == RW'(IMAGE_HEIGHT - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // The emit decision uses the position of the pixel being accepted, before the counters advance.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_s1 <= 1'b0;
      valid_s2 <= 1'b0;
    end else begin
      valid_s1 <= accept && (row >= RW'(2)) && (col >= CW'(2));
      valid_s2 <= valid_s1;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    pix_t            line_prev  [IMAGE_WIDTH];
    pix_t            line_prev2 [IMAGE_WIDTH];
    pix_t            above1, above2;
    pix_t [2:0][2:0] win;
    logic [PW-1:0]   gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [DW-1:0] gx_diff, gy_diff;
    logic [DW-1:0]   gx_abs, gy_abs;

    assign above1 = line_prev[col];
    assign above2 = line_prev2[col];

    // NOTE: the line buffers have no reset, so they map onto plain RAM. A stale entry is never
    // used, because a window is emitted only after two rows of the current frame are written.
    always_ff @(posedge i_clk) begin
      if (accept) begin
        line_prev[col]  <= stream.i_pixel[ch];
        line_prev2[col] <= above1;
      end
    end

    // Window row 0 holds the oldest line and column 2 holds the newest pixel.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        win <= '0;
      end else if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= above2;
        win[1][2] <= above1;
        win[2][2] <= stream.i_pixel[ch];
      end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        gx_pos <= '0;
        gx_neg <= '0;
        gy_pos <= '0;
        gy_neg <= '0;
      end else begin
        gx_pos <= PW'(win[0][2]) + PW'({win[1][2], 1'b0}) + PW'(win[2][2]);
        gx_neg <= PW'(win[0][0]) + PW'({win[1][0], 1'b0}) + PW'(win[2][0]);
        gy_pos <= PW'(win[2][0]) + PW'({win[2][1], 1'b0}) + PW'(win[2][2]);
        gy_neg <= PW'(win[0][0]) + PW'({win[0][1], 1'b0}) + PW'(win[0][2]);
      end
    end

    assign gx_diff = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    assign gy_diff = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    assign gx_abs  = gx_diff[DW-1] ? DW'(-gx_diff) : DW'(gx_diff);
    assign gy_abs  = gy_diff[DW-1] ? DW'(-gy_diff) : DW'(gy_diff);
    // |G| is at most 4*(2^N-1), so the result after >>2 always fits in N bits.
    assign gx_mag[ch] = COLOR_CHANNEL'(gx_abs >> 2);
    assign gy_mag[ch] = COLOR_CHANNEL'(gy_abs >> 2);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stream.o_data_ready        <= 1'b0;
      stream.o_convolution_value <= '0;
    end else begin
      stream.o_data_ready <= valid_s2;
      if (valid_s2) begin
        for (int ch = 0; ch < 3; ch++) begin
          stream.o_convolution_value[0][ch] <= gx_mag[ch];
          stream.o_convolution_value[1][ch] <= gy_mag[ch];
        end
      end
    end
  end
endmodule

// File: tb/tb_sobel_gradient.sv
// Scoreboard bench for sobel_gradient on an 8x6 image. Expected gradients are computed directly from
// the generated image, queued with their due cycle, and compared when the DUT pulses.
module tb_sobel_gradient;
  localparam int CC = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  typedef struct {
    logic [47:0] val;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   nz_pulses = 0;
  exp_t sb_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_gradient_if #(.COLOR_CHANNEL(CC)) bus ();

  sobel_gradient #(
    .COLOR_CHANNEL(CC),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .stream (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Image kinds: 0 uniform 100, 1 vertical edge, 2 horizontal edge on ch1, 3 all 255, 4 all 0.
  function automatic logic [23:0] pix(input int kind, input int r, input int c);
    case (kind)
      0:       return {3{8'd100}};
      1:       return (c >= 4) ? {3{8'd255}} : 24'd0;
      2:       return (r >= 3) ? {8'd0, 8'd200, 8'd0} : 24'd0;
      3:       return {3{8'd255}};
      default: return 24'd0;
    endcase
  endfunction

  function automatic logic [47:0] expect_at(input int kind, input int r, input int c);
    logic [47:0] v;
    logic [23:0] px;
    int p [3][3];
    int gx, gy;
    v = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          px = pix(kind, r - 2 + i, c - 2 + j);
          p[i][j] = int'(px[ch*8 +: 8]);
        end
      gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
      gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
      if (gx < 0) gx = -gx;
      if (gy < 0) gy = -gy;
      v[ch*8 +: 8]      = 8'(gx >> 2);
      v[24 + ch*8 +: 8] = 8'(gy >> 2);
    end
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.o_data_ready) begin
        pulses++;
        if (bus.o_convolution_value != '0) nz_pulses++;
        if (sb_q.size() == 0) begin
          check("spurious pulse", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("pulse cycle", 64'(cyc), 64'(e.due));
          check("gradient value", 64'(bus.o_convolution_value), 64'(e.val));
        end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        check("missing pulse", 64'd0, 64'd1);
        void'(sb_q.pop_front());
      end
    end
  end

  // Drives pixels from 0 up to, but not including, linear index stop_at. The last pixel is left on the bus.
  task automatic send_frame(input int kind, input int max_gap, input int stop_at);
    exp_t e;
    int   gap;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r*W + c == stop_at) return;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
          @(posedge clk); #1;
          bus.i_data_ready = 1'b0;
          bus.i_pixel      = 24'($urandom);
        end
        @(posedge clk); #1;
        bus.i_data_ready = 1'b1;
        bus.i_pixel      = pix(kind, r, c);
        if (r >= 2 && c >= 2) begin
          e.val = expect_at(kind, r, c);
          e.due = cyc + 3;
          sb_q.push_back(e);
        end
      end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.i_data_ready = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    check("drain queue empty", 64'(sb_q.size()), 64'd0);
    idle(2);
  endtask

  task automatic run_frame(input string name, input int kind, input int gap,
                           input int want_pulses, input int want_nz);
    int p0, n0;
    p0 = pulses;
    n0 = nz_pulses;
    send_frame(kind, gap, -1);
    idle(1);
    drain();
    check({name, " pulse count"}, 64'(pulses - p0), 64'(want_pulses));
    check({name, " nonzero count"}, 64'(nz_pulses - n0), 64'(want_nz));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst              = 1'b1;
    bus.i_data_ready = 1'b0;
    bus.i_pixel      = '0;
    @(posedge clk); #1;
    check("reset data_ready", 64'(bus.o_data_ready), 64'd0);
    check("reset value", 64'(bus.o_convolution_value), 64'd0);
    rst = 1'b0;
    idle(2);

    run_frame("uniform", 0, 0, 24, 0);
    run_frame("vertical", 1, 0, 24, 8);
    run_frame("horizontal", 2, 0, 24, 12);
    run_frame("gapped", 1, 5, 24, 8);

    // Reset while pixels (3,2)..(3,4) are still in the pipeline.
    send_frame(1, 0, 3*W + 5);
    @(posedge clk); #1;
    bus.i_data_ready = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("mid reset data_ready", 64'(bus.o_data_ready), 64'd0);
    check("mid reset value", 64'(bus.o_convolution_value), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_frame("after reset", 1, 0, 24, 8);

    p0 = pulses;
    send_frame(3, 0, -1);
    send_frame(4, 0, -1);
    idle(1);
    drain();
    check("back-to-back pulse count", 64'(pulses - p0), 64'd48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
